// File: rtl/signed_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : signed_div_pkg
// Brief    : Shared constants, state encoding and helpers for the signed
//            8-bit iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
package signed_div_pkg;

    localparam int WIDTH = 8;
    localparam int STEPS = 8;

    localparam logic [WIDTH-1:0] Q_DIV0 = 8'hFF;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] SIGN = 2'd2;

    // Two's-complement negation; -8'h80 stays 8'h80.
    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module   : ripple_carry_adder
// Brief    : Parameterised ripple-carry adder with carry in/out.
// Revision : 1.0 - initial release
// ============================================================================
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[WIDTH];

endmodule
`default_nettype wire

// File: rtl/signed_8bit_divider.sv
`default_nettype none
// ============================================================================
// Module   : signed_8bit_divider
// Brief    : Iterative signed divider, restoring division on magnitudes with a
//            final sign-correction cycle; truncates toward zero.
// Revision : 1.0 - initial release
// ============================================================================
module signed_8bit_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    import signed_div_pkg::*;

    localparam logic [2:0] c_LAST = 3'(STEPS - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_dmag;
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_zdvd;
    logic [2:0]       r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_ovf_pend;
    logic             r_zero_pend;

    logic             w_accept;
    logic             w_div0;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_diff;
    logic             w_nob;

    // A zero-divisor result is still in flight while r_zero_pend is set,
    // so a new request is held off for that one cycle.
    assign w_accept  = start && (r_state == IDLE) && !r_zero_pend;
    assign w_div0    = (divisor == '0);
    assign w_dvd_mag = dividend[WIDTH-1] ? twos_neg(dividend) : dividend;
    assign w_dvs_mag = divisor[WIDTH-1]  ? twos_neg(divisor)  : divisor;
    assign w_s       = {r_rem[WIDTH-2:0], r_dq[WIDTH-1]};
    assign busy      = (r_state == CALC) || (r_state == SIGN);

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_trial_sub (
        .a    (w_s),
        .b    (~r_dmag),
        .cin  (1'b1),
        .s    (w_diff),
        .cout (w_nob)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_div0) w_state_nxt = CALC;
            CALC:    if (r_cnt == c_LAST) w_state_nxt = SIGN;
            SIGN:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dmag      <= '0;
            r_dq        <= '0;
            r_rem       <= '0;
            r_zdvd      <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_ovf_pend  <= 1'b0;
            r_zero_pend <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;

            if (r_zero_pend) begin
                r_zero_pend <= 1'b0;
                quotient    <= Q_DIV0;
                remainder   <= r_zdvd;
                div_by_zero <= 1'b1;
                overflow    <= 1'b0;
                done        <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (w_div0) begin
                            r_zero_pend <= 1'b1;
                            r_zdvd      <= dividend;
                        end else begin
                            r_dmag     <= w_dvs_mag;
                            r_dq       <= w_dvd_mag;
                            r_rem      <= '0;
                            r_cnt      <= '0;
                            r_neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_neg_r    <= dividend[WIDTH-1];
                            r_ovf_pend <= (dividend == 8'h80) && (divisor == 8'hFF);
                        end
                    end
                end
                CALC: begin
                    // Carry out of S + ~|divisor| + 1 means no borrow.
                    r_rem <= w_nob ? w_diff : w_s;
                    r_dq  <= {r_dq[WIDTH-2:0], w_nob};
                    r_cnt <= r_cnt + 3'd1;
                end
                SIGN: begin
                    quotient  <= r_neg_q ? twos_neg(r_dq)  : r_dq;
                    remainder <= r_neg_r ? twos_neg(r_rem) : r_rem;
                    overflow  <= r_ovf_pend;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/signed_8bit_divider.md
# signed_8bit_divider

Iterative signed 8-bit divider: the inverse companion of the signed 8-bit multiplier datapath. Accepts a two's-complement dividend and divisor on a `start` pulse and computes quotient and remainder by restoring division on magnitudes, one bit per cycle. It reuses the team's 8-bit `ripple_carry_adder` for the trial subtraction, then applies a sign-correction cycle. Results use truncation toward zero, with the remainder taking the sign of the dividend.

## Interface
- `WIDTH`, 8, operand width; only 8 is supported.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `dividend` input 8: signed two's-complement; sampled with `start`.
- `divisor` input 8: signed two's-complement; sampled with `start`.
- `busy` output 1: high while in CALC or SIGN.
- `done` output 1: one-cycle pulse; results are valid from this cycle onward.
- `quotient` output 8: signed result.
- `remainder` output 8: signed result.
- `div_by_zero` output 1: flag for the last operation; valid with `done`.
- `overflow` output 1: flag for the last operation (−128 / −1); valid with `done`.

## Operation
- States and transitions:
  - IDLE → CALC on `start` with a nonzero divisor.
  - IDLE → IDLE on `start` with a zero divisor (fast path).
  - CALC → SIGN after 8 steps.
  - SIGN → IDLE.
- Load, at the edge sampling `start`:
  - Unsigned 8-bit magnitudes `|dividend|` and `|divisor|` are latched; |−128| = 8'h80.
  - Latched signs: `neg_q = dividend[7] ^ divisor[7]` and `neg_r = dividend[7]`.
  - Partial remainder R is cleared and the step counter is cleared.
- CALC step, one per cycle, MSB first:
  - `S = {R[6:0], next dividend bit}`.
  - Trial: `S + ~|divisor| + 1`, using the adder with `cin = 1`.
  - Adder `cout = 1` means S ≥ |divisor|: R takes the trial difference and the quotient bit is 1.
  - Otherwise R = S and the quotient bit is 0.
  - R always fits in 8 bits because |divisor| ≤ 128.
- SIGN cycle: `quotient = neg_q ? −Qmag : Qmag` and `remainder = neg_r ? −R : R`, both in 8-bit two's complement. Both are registered, and `done` is set.
- Overflow: −128 / −1 gives Qmag = 8'h80, which stays 8'h80 (−128), with remainder 0 and `overflow = 1`.
- Divide by zero:
  - No iteration is performed.
  - Outputs: `quotient = 8'hFF`, `remainder = dividend`, `div_by_zero = 1`, `overflow = 0`.
- Flags are cleared at each accepted `start` and set only by the operation that owns them.
- `quotient`, `remainder` and the flags hold until the next completion or reset.

## Timing
- Let edge k be the edge that samples `start`.
- Normal path:
  - `busy` is high after edges k through k+8.
  - `done` and the results are registered at edge k+9, so `done` is high for exactly the one cycle following k+9.
  - `done` is low after edge k+10.
- Zero-divisor path: `done` is registered at edge k+1 and `busy` never rises.
- `start` is accepted in the cycle in which `done` is high (the FSM is back in IDLE). Back-to-back throughput is one result per 9 cycles.
- `start` while `busy` is ignored; operands are not re-sampled.
- Reset values:
  - All outputs 0: `busy`, `done`, `quotient`, `remainder`, `div_by_zero`, `overflow`.
  - FSM in IDLE and counter at 0.
- `rst` mid-operation: after the reset edge the block is in IDLE with outputs 0, and no `done` pulse is emitted for the aborted operation.
- `rst` together with `start`: reset wins.

## Structure
- Shared package `signed_div_pkg` holds:
  - State encoding IDLE / CALC / SIGN.
  - `WIDTH = 8`.
  - `STEPS = 8`.
  - `Q_DIV0 = 8'hFF`.
- Sub-module: one `ripple_carry_adder` instance, with `a = S`, `b = ~|divisor|`, `cin = 1`.
  - Its `cout` is the no-borrow flag.
  - Its `s` is the trial difference.
- Magnitude and negation logic is inline.
- Datapath registers: divisor magnitude, dividend shift register (reused to collect quotient bits), R, a 3-bit step counter, and the two sign bits.

## Test plan
- 100 / 7 → `quotient` 8'h0E, `remainder` 8'h02, flags 0; `done` exactly one cycle, after edge k+9.
- −100 / 7 → 8'hF2 / 8'hFE. 100 / −7 → 8'hF2 / 8'h02. −100 / −7 → 8'h0E / 8'hFE.
- −128 / −1 → 8'h80 / 8'h00 with `overflow = 1`. −128 / 1 → 8'h80 / 8'h00 with `overflow = 0`. 127 / −128 → 8'h00 / 8'h7F.
- 5 / 0 → `done` after edge k+1, `quotient` 8'hFF, `remainder` 8'h05, `div_by_zero = 1`, `busy` never high.
- `start` pulsed with new operands mid-CALC → ignored; the result is for the original operands. `start` in the `done` cycle → the new operation completes 9 edges later.
- `rst` at CALC step 4 → next cycle all outputs 0 and no `done`. A following 50 / 3 → 8'h10 / 8'h02.
